// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states
// and the big-endian lane placement helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] OFF_B0 = 2'd0;
    localparam logic [1:0] OFF_B1 = 2'd1;
    localparam logic [1:0] OFF_B2 = 2'd2;
    localparam logic [1:0] OFF_B3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Bit position of the lane LSB inside the big-endian word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
        logic [4:0] sh;
        sh = 5'd0;
        if (size == SZ_BYTE) begin
            case (offset)
                OFF_B0:  sh = 5'd24;
                OFF_B1:  sh = 5'd16;
                OFF_B2:  sh = 5'd8;
                default: sh = 5'd0;
            endcase
        end else if (size == SZ_HALF) begin
            sh = offset[1] ? 5'd0 : 5'd16;
        end
        return sh;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = 32'h0000_00FF;
            SZ_HALF: m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane extract/extend for loads and lane merge for sub-word
// stores; one instance serves both the LOAD and RMW_WR paths.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane;

    assign w_shift = lane_shift(i_size, i_offset);
    assign w_mask  = lane_mask(i_size);
    assign w_lane  = i_word >> w_shift;

    always_comb begin
        o_load_data = w_lane;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_lane[7]}},  w_lane[7:0]};
            SZ_HALF: o_load_data = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            default: o_load_data = w_lane;
        endcase
    end

    assign o_merged = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store initiator for the word-wide big-endian Data_Memory:
// validates requests, sequences read/write strobes and returns extended load data.
module data_mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] DataAddr,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData
);

    localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_merge;

    logic [ADDR_W-1:0] w_word_idx;
    logic              w_req_err;
    logic [31:0]       w_align_word;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_word_idx = req_addr >> 2;

    always_comb begin
        case (req_size)
            SZ_BYTE: w_req_err = 1'b0;
            SZ_HALF: w_req_err = req_addr[0];
            SZ_WORD: w_req_err = |req_addr[1:0];
            default: w_req_err = 1'b1;
        endcase
        if (w_word_idx >= WORD_LIMIT) begin
            w_req_err = 1'b1;
        end
    end

    // LOAD extracts from live memory data; RMW_WR merges into the captured word.
    assign w_align_word = (r_state == ST_RMW_WR) ? r_merge : readData;

    mem_lane_align u_lane_align (
        .i_word      (w_align_word),
        .i_size      (r_size),
        .i_offset    (r_addr[1:0]),
        .i_signed    (r_signed),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)               w_state_next = ST_RESP;
                    else if (!req_write)         w_state_next = ST_LOAD;
                    else if (req_size == SZ_WORD) w_state_next = ST_WRITE;
                    else                         w_state_next = ST_RMW_RD;
                end
            end
            ST_LOAD:   w_state_next = ST_RESP;
            ST_RMW_RD: w_state_next = ST_RMW_WR;
            ST_RMW_WR: w_state_next = ST_RESP;
            ST_WRITE:  w_state_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Strobes depend only on registered state so MemWrite is glitch-free at the negedge commit.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        DataAddr   = r_addr >> 2;
        writeData  = 32'd0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                DataAddr  = '0;
            end
            ST_LOAD, ST_RMW_RD: MemRead = 1'b1;
            ST_RMW_WR: begin
                MemWrite  = 1'b1;
                writeData = w_merged;
            end
            ST_WRITE: begin
                MemWrite  = 1'b1;
                writeData = r_wdata;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = r_rdata;
            end
            default: DataAddr = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_merge  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_err    <= w_req_err;
                        r_rdata  <= 32'd0;
                    end
                end
                ST_LOAD:   r_rdata <= w_load_data;
                ST_RMW_RD: r_merge <= readData;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Randomized self-checking bench for data_mem_access_unit with a word-array
// memory responder and an arithmetic reference model of loads and stores.
module tb_data_mem_access_unit;

    localparam int MEM_WORDS = 32;
    localparam int ADDR_W    = 32;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAddr;
    logic [31:0]       writeData;
    logic [31:0]       readData;

    always #5 CLK = ~CLK;

    data_mem_access_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .DataAddr   (DataAddr),
        .writeData  (writeData),
        .readData   (readData)
    );

    // Responder memory (what the DUT talks to) and reference memory (what the model expects).
    logic [31:0] mem_arr [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    assign readData = (DataAddr < 32'(MEM_WORDS)) ? mem_arr[DataAddr[4:0]] : 32'hDEAD_BEEF;

    int          n_rd;
    int          n_wr;
    int          both_seen;
    logic [31:0] mon_addr;
    logic [31:0] mon_wdata;

    always @(negedge CLK) begin
        if (MemWrite && DataAddr < 32'(MEM_WORDS)) mem_arr[DataAddr[4:0]] <= writeData;
        if (MemRead) begin
            n_rd     = n_rd + 1;
            mon_addr = DataAddr;
        end
        if (MemWrite) begin
            n_wr      = n_wr + 1;
            mon_addr  = DataAddr;
            mon_wdata = writeData;
        end
        if (MemRead && MemWrite) both_seen = 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
        end
    endtask

    // Reference model: lane position/mask from the big-endian byte numbering.
    function automatic logic [31:0] m_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int m_shift(input logic [1:0] sz, input int off);
        if (sz == 2'd0) return 8 * (3 - off);
        if (sz == 2'd1) return 16 * (1 - off / 2);
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input int off);
        logic [31:0] m;
        logic [31:0] v;
        m = m_mask(sz);
        v = (w >> m_shift(sz, off)) & m;
        if (sg && sz != 2'd2 && (v & ((m >> 1) + 32'd1)) != 32'd0) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] wd, input int off);
        logic [31:0] m;
        int          sh;
        m  = m_mask(sz);
        sh = m_shift(sz, off);
        return (w & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem_arr[idx] = val;
        ref_mem[idx] = val;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] idx;
        int          off;
        bit          err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        int          lat;

        idx = addr >> 2;
        off = int'(addr & 32'd3);
        err = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0)
              || (idx >= 32'(MEM_WORDS));
        exp_rdata = 32'd0;
        exp_wdata = 32'd0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            exp_rdata = m_load(ref_mem[idx[4:0]], sz, sg, off);
        end else if (sz == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            exp_wdata = wd;
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 1;
            exp_wdata = m_store(ref_mem[idx[4:0]], sz, wd, off);
        end
        n_txn++;

        n_rd = 0;
        n_wr = 0;
        @(negedge CLK);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("resp_err", 32'(resp_err), 32'(err));
        check_val("resp_rdata", resp_rdata, exp_rdata);
        check_val("read_strobes", 32'(n_rd), 32'(exp_rd));
        check_val("write_strobes", 32'(n_wr), 32'(exp_wr));
        if (!err) check_val("data_addr", mon_addr, idx);
        if (!err && wr) check_val("write_data", mon_wdata, exp_wdata);

        for (int h = 0; h < hold; h++) begin
            @(posedge CLK);
            #1;
            check_val("hold_valid", 32'(resp_valid), 32'd1);
            check_val("hold_rdata", resp_rdata, exp_rdata);
            check_val("hold_err", 32'(resp_err), 32'(err));
            check_val("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        resp_ready = 1'b0;
        check_val("resp_drop", 32'(resp_valid), 32'd0);
        check_val("ready_return", 32'(req_ready), 32'd1);

        if (wr && !err) ref_mem[idx[4:0]] = exp_wdata;
        $display("txn %0d wr=%0d sz=%0d sg=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
                 n_txn, wr, sz, sg, addr, wd, resp_rdata, resp_err, lat);
    endtask

    initial begin
        logic [31:0] saved;
        logic [1:0]  rsz;
        logic [31:0] raddr;
        int          r;

        n_rd = 0; n_wr = 0; both_seen = 0;
        mon_addr = 32'd0; mon_wdata = 32'd0;
        for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
        Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(resp_err), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_memread", 32'(MemRead), 32'd0);
        check_val("rst_memwrite", 32'(MemWrite), 32'd0);
        check_val("rst_dataaddr", DataAddr, 32'd0);
        check_val("rst_writedata", writeData, 32'd0);
        Reset = 1'b0;

        // Word store then load, with backpressure on the load response.
        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 3);
        // Signed/unsigned byte loads.
        preload(4, 32'h80FF_7F01);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        // Byte store read-modify-write.
        preload(1, 32'hAABB_CCDD);
        do_req(1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_005A, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0);
        // Halfword store and signed load.
        preload(3, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_1234, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_8001, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 1);
        // Error cases.
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 2);
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'h81, 32'hFF, 0);

        // Reset while in RMW_RD aborts the store with no write and no response.
        saved = ref_mem[5];
        n_rd = 0; n_wr = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h15; req_wdata = 32'h0000_00C3;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        check_val("abort_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("abort_no_resp", 32'(resp_valid), 32'd0);
            @(posedge CLK);
            #1;
        end
        check_val("abort_no_write", 32'(n_wr), 32'd0);
        check_val("abort_mem", mem_arr[5], saved);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            raddr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300))
                                                : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 7) begin
                if (rsz == 2'd1) raddr = raddr & ~32'd1;
                if (rsz == 2'd2) raddr = raddr & ~32'd3;
            end
            do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr,
                   $urandom, int'($urandom_range(0, 3)));
        end

        check_val("strobe_exclusive", 32'(both_seen), 32'd0);
        for (int i = 0; i < MEM_WORDS; i++) check_val("final_mem", mem_arr[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
Load/store initiator between the CPU datapath and the word-wide, big-endian Data_Memory responder. It accepts byte, halfword and word load/store requests over a valid/ready handshake. It drives the MemRead/MemWrite/DataAddr/writeData strobes, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data. It sits in the MEM stage and stalls the pipeline through req_ready.

Parameters:
MEM_WORDS, 32, number of 32-bit words in data memory; valid word indices are 0..MEM_WORDS-1.
ADDR_W, 32, width of the CPU byte address and of DataAddr.

Ports:
CLK  in  1  system clock; all state changes on posedge.
Reset  in  1  synchronous, active-high reset.
req_valid  in  1  CPU request present.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  response available; held until resp_ready.
resp_ready  in  1  CPU takes the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  request was misaligned, had an illegal size, or was out of range.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe; memory commits on negedge CLK.
DataAddr  out  ADDR_W  word index, equal to req_addr >> 2.
writeData  out  32  full word to write.
readData  in  32  combinational memory read data.

Behaviour:
- Reset (synchronous): state goes to IDLE. Outputs after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, DataAddr=0, writeData=0.
- Strobes are decoded from the registered state only, so MemWrite is stable for the whole cycle around the negedge commit.
- Acceptance: a request is taken on a posedge with req_valid && req_ready. The unit latches addr, size, signed, write and wdata at that edge.
- Error check at acceptance. The request is an error if any of these hold:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - addr>>2 ≥ MEM_WORDS.
  On error the next state is RESP with resp_err=1. No memory strobe is ever asserted for an error.
- States and transitions:
  - IDLE: go to LOAD (load), WRITE (word store), RMW_RD (byte/half store) or RESP (error).
  - LOAD: MemRead=1. Capture readData at the end of the cycle, extract the addressed lane, extend it, and go to RESP.
  - RMW_RD: MemRead=1. Capture readData into the merge register and go to RMW_WR.
  - RMW_WR: MemWrite=1. writeData = captured word with the addressed lane replaced by the low bits of wdata. Go to RESP.
  - WRITE: MemWrite=1, writeData=wdata. Go to RESP.
  - RESP: resp_valid=1. Return to IDLE on a posedge with resp_ready=1; otherwise hold all response outputs stable.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
  Minimum issue interval is latency + 1.
- Lane mapping (big-endian):
  - byte offset 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0];
  - half offset 0→[31:16], 2→[15:0].
- Sign extension replicates the lane MSB.
- DataAddr holds the latched word index for every state except IDLE; it is 0 in IDLE. MemRead and MemWrite are never both high.
- Reset mid-operation: the state returns to IDLE at the reset edge. If reset is sampled during RMW_WR or WRITE, that cycle's negedge write still commits. No response is issued for an aborted request.
- While in RESP, req_valid is ignored (req_ready=0).

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding (IDLE, LOAD, RMW_RD, RMW_WR, WRITE, RESP);
  - lane-offset constants.
- One combinational sub-module, mem_lane_align, provides the lane extract+extend function and the lane merge function. It is shared by the LOAD and RMW_WR paths.

Test Plan:
- Word store then load. Store 0x11223344 at addr 0x08, then load word from 0x08 → MemWrite pulses for 1 cycle with DataAddr=2; load returns 0x11223344, err=0, resp_valid 2 cycles after accept.
- Signed vs unsigned byte load. Preload word 0x80FF7F01 at 0x10. lb 0x10 → 0xFFFFFF80; lbu 0x11 → 0x000000FF; lb 0x12 → 0x0000007F; lbu 0x13 → 0x00000001.
- Byte store RMW. Preload 0xAABBCCDD at 0x04, store byte 0x5A to 0x06 → RMW_RD then RMW_WR; writeData=0xAABB5ADD; a reload of the word returns 0xAABB5ADD; resp 3 cycles after accept.
- Halfword store and signed load. sh 0x1234 to 0x0E (preload 0), then lh 0x0E → word becomes 0x00001234; load returns 0x00001234. With 0x8001 stored instead, lh returns 0xFFFF8001.
- Errors. Each of these → resp_err=1 after 1 cycle, resp_rdata=0, and MemRead/MemWrite stay 0 throughout:
  - word load at 0x06;
  - half at 0x03;
  - size 11;
  - address 0x80 with MEM_WORDS=32.
- Backpressure and reset. Hold resp_ready=0 for 3 cycles → resp_valid and rdata stable, req_ready=0. Assert Reset during RMW_RD → no write occurs, resp_valid never rises, req_ready=1 on the next cycle.
